// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, open-drain bit shifting on device clock
// falling edges, device acknowledge check and transfer timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned MaxCnt = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StShift,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      data_q, data_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [1:0]      clk_sync_q;
    logic [1:0]      data_sync_q;
    logic            clk_prev_q;

    logic            fe;
    logic            parity;
    logic            timeout;
    logic            abort;

    // Synchronizers reset to the idle-high line level so no false edge follows reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            data_sync_q <= {data_sync_q[0], PS2_DATA};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign fe      = clk_prev_q & ~clk_sync_q[1];
    assign parity  = ~^data_q;
    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        data_d    = data_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        abort     = 1'b0;

        case (state_q)
            StIdle: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                ready_d   = 1'b1;
                if (tx_valid && ready_q) begin
                    data_d   = tx_data;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = StReq;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReq: begin
                // Releasing the clock with data held low is the start bit.
                clk_oe_d = 1'b0;
                bitcnt_d = '0;
                cnt_d    = '0;
                state_d  = StShift;
            end
            StShift: begin
                cnt_d = cnt_q + CntW'(1);
                if (timeout) begin
                    abort = 1'b1;
                end else if (fe) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q < 4'd8) begin
                        data_oe_d = ~data_q[bitcnt_q[2:0]];
                    end else if (bitcnt_q == 4'd8) begin
                        data_oe_d = ~parity;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = StAck;
                    end
                end
            end
            StAck: begin
                cnt_d = cnt_q + CntW'(1);
                if (timeout) begin
                    abort = 1'b1;
                end else if (fe) begin
                    if (!data_sync_q[1]) begin
                        state_d = StWaitIdle;
                    end else begin
                        err_d   = 1'b1;
                        ready_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitIdle: begin
                cnt_d = cnt_q + CntW'(1);
                if (timeout) begin
                    abort = 1'b1;
                end else if (clk_sync_q[1] && data_sync_q[1]) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                abort = 1'b1;
            end
        endcase

        if (abort) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            cnt_d     = '0;
            err_d     = 1'b1;
            ready_d   = 1'b1;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            data_q    <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            data_q    <= data_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model on the shared lines.
module tb_ps2_host_tx;

    localparam int unsigned INHIBIT = 5000;
    localparam int unsigned TIMEOUT = 3000;
    localparam int          HALF    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    wire        PS2_CLK  = ~(ps2_clk_oe | dev_clk_low);
    wire        PS2_DATA = ~(ps2_data_oe | dev_data_low);

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int clk_run = 0;
    int both_run = 0;
    int last_clk_run = 0;
    int last_both_run = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Pulse counters and length of each clock-inhibit run (and its overlap with data low).
    always @(negedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err) err_cnt <= err_cnt + 1;
        if (ps2_clk_oe) begin
            clk_run  <= clk_run + 1;
            both_run <= both_run + (ps2_data_oe ? 1 : 0);
        end else if (clk_run != 0) begin
            last_clk_run  <= clk_run;
            last_both_run <= both_run;
            clk_run       <= 0;
            both_run      <= 0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'hA5;
    endtask

    // Device: wait for request-to-send, then n_edges clock pulses sampling data in the high phase.
    task automatic device_frame(input int n_edges, input bit do_ack,
                                output logic [10:0] bits, output bit ok);
        int waited = 0;
        bits = '0;
        while (!(PS2_CLK === 1'b1 && PS2_DATA === 1'b0) && waited < 20000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        ok = (waited < 20000);
        if (ok) begin
            for (int i = 0; i < n_edges; i++) begin
                repeat (HALF) @(posedge clk);
                #1;
                if (i < 11) bits[i] = PS2_DATA;
                if (i == 10 && do_ack) begin
                    dev_data_low = 1'b1;
                    repeat (5) @(posedge clk);
                    #1;
                end
                dev_clk_low = 1'b1;
                repeat (HALF) @(posedge clk);
                #1;
                dev_clk_low = 1'b0;
            end
            repeat (5) @(posedge clk);
            #1;
            dev_data_low = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 10000",
                     {tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe});
        end
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b want 100", {tx_ready, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_send_ed;
        logic [10:0] bits;
        bit          ok;
        int          d0, e0, w;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hED);
        n_checks++;
        if ({tx_ready, ps2_clk_oe} !== 2'b01) begin
            n_fail++;
            $display("FAIL ed_accept: ready/clk_oe got %b want 01", {tx_ready, ps2_clk_oe});
        end
        device_frame(11, 1'b1, bits, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL ed_rts: got %0d want 1", ok); end
        n_checks++;
        if (last_clk_run !== INHIBIT + 1) begin
            n_fail++;
            $display("FAIL ed_inhibit_len: got %0d want %0d", last_clk_run, INHIBIT + 1);
        end
        n_checks++;
        if (last_both_run !== 1) begin
            n_fail++;
            $display("FAIL ed_req_len: got %0d want 1", last_both_run);
        end
        n_checks++;
        if (bits !== 11'b1_1_11101101_0) begin
            n_fail++;
            $display("FAIL ed_frame: got %b want %b", bits, 11'b1_1_11101101_0);
        end
        w = 0;
        while (tx_done !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ed_ready_at_done: got %b want 1", tx_ready);
        end
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL ed_pulses: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits;
        bit          ok;
        int          d0, w;
        d0 = done_cnt;
        send_byte(8'h07);
        device_frame(11, 1'b1, bits, ok);
        n_checks++;
        if (bits !== 11'b1_0_00000111_0 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_07_frame: got %b ok %0d want %b", bits, ok, 11'b1_0_00000111_0);
        end
        w = 0;
        while (tx_done !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        n_checks++;
        if (tx_ready !== 1'b1 || tx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done_ready: done %b ready %b want 1 1", tx_done, tx_ready);
        end
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        n_checks++;
        if ({tx_ready, ps2_clk_oe} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_accept: ready/clk_oe got %b want 01", {tx_ready, ps2_clk_oe});
        end
        device_frame(11, 1'b1, bits, ok);
        n_checks++;
        if (bits !== 11'b1_1_00000000_0 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_00_frame: got %b ok %0d want %b", bits, ok, 11'b1_1_00000000_0);
        end
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0);
        end
    endtask

    task automatic test_no_ack;
        logic [10:0] bits;
        bit          ok;
        int          d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hAA);
        device_frame(11, 1'b0, bits, ok);
        n_checks++;
        if (bits !== 11'b1_1_10101010_0 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL nack_frame: got %b ok %0d want %b", bits, ok, 11'b1_1_10101010_0);
        end
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            n_fail++;
            $display("FAIL nack_pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0);
        end
        n_checks++;
        if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin
            n_fail++;
            $display("FAIL nack_idle: got %b want 100", {tx_ready, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_timeout;
        int w, n, e0;
        e0 = err_cnt;
        send_byte(8'h12);
        w = 0;
        while (ps2_clk_oe !== 1'b0 && w < 8000) begin @(negedge clk); w++; end
        n = 0;
        while (tx_err !== 1'b1 && n < TIMEOUT + 100) begin @(negedge clk); n++; end
        n_checks++;
        if (n !== TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d want %0d", n, TIMEOUT);
        end
        n_checks++;
        if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin
            n_fail++;
            $display("FAIL timeout_release: got %b want 100", {tx_ready, ps2_clk_oe, ps2_data_oe});
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_err_count: got %0d want 1", err_cnt - e0);
        end
    endtask

    task automatic test_mid_frame_reset;
        logic [10:0] bits;
        bit          ok;
        int          d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h00);
        device_frame(4, 1'b0, bits, ok);
        n_checks++;
        if (ps2_data_oe !== 1'b1 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_data_oe: got %b ok %0d want 1", ps2_data_oe, ok);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe} !== 5'b10000) begin
            n_fail++;
            $display("FAIL rst_async: got %b want 10000",
                     {tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe});
        end
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL rst_no_pulse: done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
        end
        send_byte(8'hFF);
        device_frame(11, 1'b1, bits, ok);
        n_checks++;
        if (bits !== 11'b1_1_11111111_0 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ff_frame: got %b ok %0d want %b", bits, ok, 11'b1_1_11111111_0);
        end
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            n_fail++;
            $display("FAIL rst_ff_pulses: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_busy_ignore;
        logic [10:0] bits;
        bit          ok;
        int          d0, w;
        d0 = done_cnt;
        send_byte(8'hED);
        fork
            device_frame(11, 1'b1, bits, ok);
            begin
                w = 0;
                while (ps2_clk_oe !== 1'b0 && w < 8000) begin @(posedge clk); #1; w++; end
                repeat (100) @(posedge clk);
                #1;
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
            end
        join
        n_checks++;
        if (bits !== 11'b1_1_11101101_0 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_frame: got %b ok %0d want %b", bits, ok, 11'b1_1_11101101_0);
        end
        repeat (100) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 1 || {tx_ready, ps2_clk_oe} !== 2'b10) begin
            n_fail++;
            $display("FAIL busy_not_queued: done %0d ready/clk_oe %b want 1 10",
                     done_cnt - d0, {tx_ready, ps2_clk_oe});
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_back_to_back();
        test_no_ack();
        test_timeout();
        test_mid_frame_reset();
        test_busy_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared PS/2 clock/data lines using the standard request-to-send sequence, open-drain signalling and device acknowledge. It sits beside the PS/2 receiver in the calculator front end. Both blocks observe the same pins; this block drives them only through active-high pull-low enables.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles PS2_CLK is held low before the start bit (≥100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: max clk cycles from clock release to transfer end (15 ms at 50 MHz).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- tx_data  in  8  byte to send, sampled on accept.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready at a clk edge.
- tx_ready  out  1  high only in IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and acknowledged.
- tx_err  out  1  one-cycle pulse: no ack or timeout.
- PS2_CLK  in  1  raw clock pin level (async).
- PS2_DATA  in  1  raw data pin level (async).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release (high-Z).
- ps2_data_oe  out  1  1 = pull PS2_DATA low, 0 = release.

## Operation
- PS2_CLK and PS2_DATA pass through 2-FF synchronizers. Falling edge (fe) = previous synced clock 1, current 0.
- Parity bit = ~^tx_data (odd parity). Frame = start 0, d0..d7 LSB first, parity, stop 1, device ack 0.
- A bit value 1 is sent as oe=0 and a bit value 0 as oe=1, so the line is only ever pulled low or released.
- States:
  - IDLE: both oe=0, tx_ready=1. On accept, latch tx_data and go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then REQ.
  - REQ: clk_oe=1, data_oe=1 for 1 cycle, then SHIFT. Clear bitcnt and timeout counter.
  - SHIFT: clk_oe=0, data_oe holds the current bit (start bit first). On each fe, bitcnt k=0..7 drives ~d[k], k=8 drives ~parity, and k=9 sets data_oe=0 (stop) and goes to ACK. bitcnt increments on every fe.
  - ACK: on the next fe, a synced PS2_DATA of 0 goes to WAIT_IDLE; a 1 pulses tx_err and goes to IDLE.
  - WAIT_IDLE: when synced clock and data are both 1, pulse tx_done and go to IDLE.
- Timeout: the counter runs in SHIFT/ACK/WAIT_IDLE. At TIMEOUT_CYCLES it releases both lines, pulses tx_err and goes to IDLE. Timeout wins over an fe in the same cycle.
- tx_valid while not ready is ignored and not queued. tx_data changes after accept have no effect.
- Device activity seen in IDLE is ignored. The inhibit from a new request legally aborts any device frame in progress.
- Reset: async assertion immediately forces IDLE, both oe=0, tx_done=tx_err=0, tx_ready=1, counters 0, and latched data 0. This also applies mid-frame.

## Timing
- Reset values: tx_ready=1, tx_done=0, tx_err=0, ps2_clk_oe=0, ps2_data_oe=0.
- All outputs are registered.
- clk_oe rises the cycle after accept and stays 1 for INHIBIT_CYCLES+1 cycles (INHIBIT plus REQ).
- data_oe rises in REQ, 1 cycle before clk_oe falls.
- Pin fall to oe update is 3 clk edges (2 sync + edge register). This is well inside the device's ≥5 µs low phase.
- tx_ready falls the cycle after accept. It returns to 1 in the same cycle as the tx_done or tx_err pulse.
- Exactly one of tx_done or tx_err pulses per accepted byte, unless reset intervenes, in which case neither pulses.

## Test plan
- Send 0xED to a device model that acks. Required: clk held low 5000 cycles; sampled bits on rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once and tx_err stays 0.
- Send 0x07. Required: parity bit 0. Then back-to-back 0x00 accepted on the cycle tx_ready returns, with parity 1.
- Model clocks 11 edges but leaves data high at the ack edge. Required: tx_err pulse, both oe=0, tx_ready=1, no tx_done.
- Model never clocks after release. Required: tx_err exactly TIMEOUT_CYCLES cycles after entering SHIFT, both lines released.
- Assert rst low after the 4th fe. Required: both oe drop to 0 asynchronously, no done/err pulse, and a clean 0xFF frame after release.
- Pulse tx_valid with 0x55 during SHIFT of 0xED. Required: ignored, only 0xED appears on the line.
